fisc_useq_ctl: RTL and testbench
================================

# fisc_useq_ctl

Parametrised microsequencer and control-flow unit for the next FISC CPU generation. It replaces the fixed 4-bit microstep counter, 8-bit instruction register and 8-input jump multiplexer with one synchronous block. The block adds wait-state stalling, a jump-condition polarity bit, microstep-overflow fault detection and a halt/resume state. It sits between the data bus and the external decode ROM: it holds the IR and step count, presents the decode-ROM index, and drives the PC-load strobe.

## Interface
Parameters:
- IR_WIDTH, 8, instruction register width.
- STEP_WIDTH, 4, microstep counter width; the last step is 2^STEP_WIDTH-1.
- NUM_COND, 8, number of jump condition inputs; a power of two, at least 2.
- CSEL_W, $clog2(NUM_COND), condition select width; CSEL_W+1 must not exceed IR_WIDTH.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_databus  in  IR_WIDTH  data bus value, loaded into the IR.
- i_irload  in  1  active high; load the IR this cycle.
- i_ureset  in  1  active high; the microstep returns to 0 at the next edge.
- i_jmpena  in  1  active high; the current microstep is a conditional jump.
- i_cond  in  NUM_COND  active-high status lines (flags, UART ready, ...).
- i_stall  in  1  active high; a wait state that freezes the sequencer.
- i_resume  in  1  active high; leave HALT.
- i_halt  in  1  active high; request HALT.
- o_decode_index  out  IR_WIDTH+STEP_WIDTH  {IR, step}, the decode-ROM address.
- o_ir  out  IR_WIDTH  IR contents.
- o_step  out  STEP_WIDTH  current microstep.
- o_pcload  out  1  active high; the PC loads from AR this cycle.
- o_fault  out  1  sticky; microstep overflow occurred.
- o_halted  out  1  high while the state is HALT.

## Operation
- Reset values (asynchronous, while reset=0): IR=0, step=0, state=RUN, o_fault=0, o_pcload=0, o_halted=0.
- States:
  - RUN: the normal state.
  - WAIT: entered while i_stall=1. It is a registered shadow of i_stall, used only for visibility and debug; it has no effect on the outputs.
  - HALT: entered from RUN or WAIT.
- RUN/WAIT, i_stall=0, at each edge:
  - if i_ureset=1, step<=0; otherwise step<=step+1;
  - if i_irload=1, IR<=i_databus;
  - the state moves to WAIT if i_stall=1 at the edge, otherwise stays RUN.
- i_stall=1: step, IR and fault hold; o_pcload is forced to 0.
- Condition decode: sel=IR[CSEL_W-1:0], pol=IR[CSEL_W]; taken = i_cond[sel] XOR pol.
- o_pcload = i_jmpena AND taken AND (state≠HALT) AND NOT i_stall. It is combinational and valid for the whole cycle.
- Overflow: step=2^STEP_WIDTH-1, not stalled, i_ureset=0 at an edge. The step then wraps to 0, o_fault is set, and the state moves to HALT.
- HALT:
  - step, IR and o_fault hold; o_pcload=0; o_decode_index is still driven.
  - i_resume=1 at an edge gives step<=0, state<=RUN, o_fault unchanged.
  - o_fault is cleared only by reset.
- i_halt=1 (not stalled) at an edge: the state moves to HALT at that edge. The step update and IR load of that edge still complete.
- Priority at an edge: reset > HALT behaviour > i_stall > overflow/i_halt > i_ureset > increment.
- i_irload and i_ureset together: both take effect, so the new IR is used with step 0.
- Reset asserted mid-microsequence: everything returns to reset values immediately, with no clock needed. The first edge after release executes step 0 of IR=0.

## Timing
- o_decode_index, o_ir, o_step, o_halted and o_fault are registered or direct from registers, so they change only after a rising edge or on reset.
- o_pcload is combinational from i_cond, i_jmpena, i_stall and the state; the latency is zero. The PC captures it at the next edge.
- The IR load takes one cycle: data on i_databus at edge N appears on o_ir after edge N.
- A stall has no added latency: deasserting i_stall before edge N lets edge N advance.

## Structure
- Shared package fisc_pkg: state encoding localparams (ST_RUN=2'd0, ST_WAIT=2'd1, ST_HALT=2'd2) and default width constants used by both the CPU top and this block.
- One natural sub-module, fisc_condmux: a NUM_COND:1 multiplexer with polarity XOR and active-high enable. It is reused by the CPU top for conditional stack operations.
- The IR and the step counter are plain registers in this block; they are not split into separate modules.

## Test plan
- Reset and increment:
  - Stimulus: release reset, hold all inputs 0 for 5 edges.
  - Required response: o_step counts 0,1,2,3,4,5; o_decode_index is 12'h000 then 12'h001 ... 12'h005.
- IR load with microstep reset:
  - Stimulus: i_databus=8'hA3, i_irload=1, i_ureset=1 at one edge.
  - Required response: o_ir=8'hA3, o_step=0, o_decode_index=12'hA30.
- Jump polarity:
  - Stimulus: IR=8'h05 (sel=5, pol=0), i_cond=8'h20, i_jmpena=1; then IR=8'h0D (sel=5, pol=1) with the same inputs.
  - Required response: o_pcload=1 for the first case and 0 for the second.
- Stall:
  - Stimulus: at step 3, hold i_stall=1 for 4 edges with i_irload=1 and i_jmpena=1 with a taken condition.
  - Required response: o_step stays 3, o_ir is unchanged, o_pcload=0; after release the next edge gives step 4.
- Overflow fault:
  - Stimulus: STEP_WIDTH=4, no i_ureset for 16 edges.
  - Required response: at step 15 the next edge gives o_step=0, o_fault=1, o_halted=1. i_resume clears o_halted but o_fault stays 1 until reset.
- Asynchronous reset mid-sequence:
  - Stimulus: at step 7 with IR=8'h5C, assert reset between edges.
  - Required response: o_step=0, o_ir=0 and o_fault=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fisc_pkg.sv
// rtl/fisc_pkg.sv - shared FISC state encodings and default widths
package fisc_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int FISC_IR_WIDTH   = 8;
  localparam int FISC_STEP_WIDTH = 4;
  localparam int FISC_NUM_COND   = 8;

endpackage

// File: rtl/fisc_condmux.sv
// rtl/fisc_condmux.sv - condition select multiplexer with polarity XOR and enable
module fisc_condmux #(
  parameter int NUM_COND = 8,
  parameter int CSEL_W   = $clog2(NUM_COND)
) (
  input  logic [NUM_COND-1:0] i_cond,
  input  logic [CSEL_W-1:0]   i_sel,
  input  logic                i_pol,
  input  logic                i_en,
  output logic                o_taken
);

  assign o_taken = i_en & (i_cond[i_sel] ^ i_pol);

endmodule

// File: rtl/fisc_useq_ctl.sv
// rtl/fisc_useq_ctl.sv - FISC microsequencer: IR, microstep counter, jump strobe, halt/fault
module fisc_useq_ctl
  import fisc_pkg::*;
#(
  parameter int IR_WIDTH   = FISC_IR_WIDTH,
  parameter int STEP_WIDTH = FISC_STEP_WIDTH,
  parameter int NUM_COND   = FISC_NUM_COND,
  parameter int CSEL_W     = $clog2(NUM_COND)
) (
  input  logic                           i_clk,
  input  logic                           reset,
  input  logic [IR_WIDTH-1:0]            i_databus,
  input  logic                           i_irload,
  input  logic                           i_ureset,
  input  logic                           i_jmpena,
  input  logic [NUM_COND-1:0]            i_cond,
  input  logic                           i_stall,
  input  logic                           i_resume,
  input  logic                           i_halt,
  output logic [IR_WIDTH+STEP_WIDTH-1:0] o_decode_index,
  output logic [IR_WIDTH-1:0]            o_ir,
  output logic [STEP_WIDTH-1:0]          o_step,
  output logic                           o_pcload,
  output logic                           o_fault,
  output logic                           o_halted
);

  logic [1:0]            state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  fault_q, fault_d;
  logic                  advance;
  logic                  step_last;
  logic                  overflow;
  logic                  cond_en;
  logic                  taken;

  assign advance   = (state_q != ST_HALT) && !i_stall;
  assign step_last = (step_q == {STEP_WIDTH{1'b1}});
  assign overflow  = step_last && !i_ureset;

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (i_resume) state_d = ST_RUN;
      end
      default: begin
        // WAIT only mirrors i_stall; it behaves exactly like RUN otherwise
        if (i_stall)                  state_d = ST_WAIT;
        else if (overflow || i_halt)  state_d = ST_HALT;
        else                          state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      step_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    step_d  = step_q;
    fault_d = fault_q;
    if (state_q == ST_HALT) begin
      if (i_resume) step_d = '0;
    end else if (!i_stall) begin
      if (i_irload) ir_d = i_databus;
      // the last step wraps to 0 on its own, so ureset and overflow share the clear
      if (i_ureset || step_last) step_d = '0;
      else                       step_d = step_q + 1'b1;
      if (overflow) fault_d = 1'b1;
    end
  end

  fisc_condmux #(
    .NUM_COND (NUM_COND),
    .CSEL_W   (CSEL_W)
  ) u_condmux (
    .i_cond  (i_cond),
    .i_sel   (ir_q[CSEL_W-1:0]),
    .i_pol   (ir_q[CSEL_W]),
    .i_en    (cond_en),
    .o_taken (taken)
  );

  always_comb begin
    cond_en        = i_jmpena && advance;
    o_pcload       = taken;
    o_halted       = (state_q == ST_HALT);
    o_fault        = fault_q;
    o_ir           = ir_q;
    o_step         = step_q;
    o_decode_index = {ir_q, step_q};
  end

endmodule

// File: tb/tb_fisc_useq_ctl.sv
// tb/tb_fisc_useq_ctl.sv - directed self-checking bench for fisc_useq_ctl
module tb_fisc_useq_ctl;

  logic        i_clk;
  logic        reset;
  logic [7:0]  i_databus;
  logic        i_irload;
  logic        i_ureset;
  logic        i_jmpena;
  logic [7:0]  i_cond;
  logic        i_stall;
  logic        i_resume;
  logic        i_halt;
  logic [11:0] o_decode_index;
  logic [7:0]  o_ir;
  logic [3:0]  o_step;
  logic        o_pcload;
  logic        o_fault;
  logic        o_halted;

  int errors = 0;
  int checks = 0;

  fisc_useq_ctl dut (
    .i_clk          (i_clk),
    .reset          (reset),
    .i_databus      (i_databus),
    .i_irload       (i_irload),
    .i_ureset       (i_ureset),
    .i_jmpena       (i_jmpena),
    .i_cond         (i_cond),
    .i_stall        (i_stall),
    .i_resume       (i_resume),
    .i_halt         (i_halt),
    .o_decode_index (o_decode_index),
    .o_ir           (o_ir),
    .o_step         (o_step),
    .o_pcload       (o_pcload),
    .o_fault        (o_fault),
    .o_halted       (o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; i_databus = '0; i_irload = 0; i_ureset = 0; i_jmpena = 0;
    i_cond = '0; i_stall = 0; i_resume = 0; i_halt = 0;
    #2;
    check("rst_step", 16'(o_step), 16'h0);
    check("rst_ir", 16'(o_ir), 16'h0);
    check("rst_fault", 16'(o_fault), 16'h0);
    check("rst_halted", 16'(o_halted), 16'h0);
    check("rst_pcload", 16'(o_pcload), 16'h0);
    edge1();
    edge1();
    reset = 1'b1;
    check("rel_index", 16'(o_decode_index), 16'h000);
    for (int i = 1; i <= 5; i++) begin
      edge1();
      check("inc_step", 16'(o_step), 16'(i));
      check("inc_index", 16'(o_decode_index), 16'(i));
    end

    i_databus = 8'hA3; i_irload = 1; i_ureset = 1;
    edge1();
    i_irload = 0; i_ureset = 0;
    check("ld_ir", 16'(o_ir), 16'h00A3);
    check("ld_step", 16'(o_step), 16'h0);
    check("ld_index", 16'(o_decode_index), 16'h0A30);

    i_databus = 8'h05; i_irload = 1; i_ureset = 1;
    edge1();
    i_irload = 0; i_ureset = 0;
    i_cond = 8'h20; i_jmpena = 1;
    #1;
    check("jmp_pol0", 16'(o_pcload), 16'h1);
    i_databus = 8'h0D; i_irload = 1;
    edge1();
    i_irload = 0;
    check("jmp_pol1", 16'(o_pcload), 16'h0);
    i_cond = 8'h00;
    #1;
    check("jmp_pol1_clr", 16'(o_pcload), 16'h1);
    i_jmpena = 0;
    #1;
    check("jmp_noena", 16'(o_pcload), 16'h0);

    i_ureset = 1;
    edge1();
    i_ureset = 0;
    edge1(); edge1(); edge1();
    check("pre_stall_step", 16'(o_step), 16'h3);
    i_stall = 1; i_irload = 1; i_databus = 8'hFF; i_jmpena = 1;
    #1;
    check("stall_pcload0", 16'(o_pcload), 16'h0);
    for (int i = 0; i < 4; i++) begin
      edge1();
      check("stall_step", 16'(o_step), 16'h3);
      check("stall_ir", 16'(o_ir), 16'h000D);
      check("stall_pcload", 16'(o_pcload), 16'h0);
    end
    i_stall = 0; i_irload = 0;
    #1;
    check("unstall_pcload", 16'(o_pcload), 16'h1);
    i_jmpena = 0;
    edge1();
    check("unstall_step", 16'(o_step), 16'h4);
    check("unstall_ir", 16'(o_ir), 16'h000D);

    i_halt = 1;
    edge1();
    i_halt = 0;
    check("halt_step", 16'(o_step), 16'h5);
    check("halt_halted", 16'(o_halted), 16'h1);
    i_jmpena = 1;
    edge1();
    check("halt_hold", 16'(o_step), 16'h5);
    check("halt_pcload", 16'(o_pcload), 16'h0);
    i_jmpena = 0; i_resume = 1;
    edge1();
    i_resume = 0;
    check("resume_step", 16'(o_step), 16'h0);
    check("resume_halted", 16'(o_halted), 16'h0);
    check("resume_fault", 16'(o_fault), 16'h0);

    for (int i = 0; i < 15; i++) edge1();
    check("ovf_pre_step", 16'(o_step), 16'hF);
    check("ovf_pre_fault", 16'(o_fault), 16'h0);
    edge1();
    check("ovf_step", 16'(o_step), 16'h0);
    check("ovf_fault", 16'(o_fault), 16'h1);
    check("ovf_halted", 16'(o_halted), 16'h1);
    edge1();
    check("ovf_hold", 16'(o_step), 16'h0);
    i_resume = 1;
    edge1();
    i_resume = 0;
    check("ovf_res_halted", 16'(o_halted), 16'h0);
    check("ovf_res_fault", 16'(o_fault), 16'h1);
    edge1();
    check("ovf_run_step", 16'(o_step), 16'h1);
    check("ovf_sticky", 16'(o_fault), 16'h1);

    i_databus = 8'h5C; i_irload = 1; i_ureset = 1;
    edge1();
    i_irload = 0; i_ureset = 0;
    for (int i = 0; i < 7; i++) edge1();
    check("arst_pre_step", 16'(o_step), 16'h7);
    check("arst_pre_ir", 16'(o_ir), 16'h005C);
    #2;
    reset = 1'b0;
    #1;
    check("arst_step", 16'(o_step), 16'h0);
    check("arst_ir", 16'(o_ir), 16'h0);
    check("arst_fault", 16'(o_fault), 16'h0);
    edge1();
    reset = 1'b1;
    edge1();
    check("arst_first_edge", 16'(o_decode_index), 16'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
